// File: rtl/divide.sv
// Sequential fixed-point fraction divider: quotient = dividend/divisor scaled so that
// all-ones means 1.0, produced by restoring division one bit per clock.
module divide #(
    parameter int unsigned DIVIDEND_WIDTH = 16,
    parameter int unsigned QUOTIENT_WIDTH = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    input  logic [DIVIDEND_WIDTH-1:0] dividend,
    input  logic [DIVIDEND_WIDTH-1:0] divisor,
    output logic                      busy,
    output logic                      done,
    output logic [QUOTIENT_WIDTH-1:0] quotient
);

    localparam int unsigned REM_WIDTH = DIVIDEND_WIDTH + 1;
    localparam int unsigned CNT_WIDTH = $clog2(QUOTIENT_WIDTH + 1);
    localparam logic [QUOTIENT_WIDTH-1:0] Q_FULL = '1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINISH} state_e;
    typedef enum logic [1:0] {C_NORM, C_ZERO, C_SAT} cls_e;

    state_e                    state_q, state_d;
    cls_e                      cls_q, cls_d;
    logic [DIVIDEND_WIDTH-1:0] divisor_q, divisor_d;
    logic [REM_WIDTH-1:0]      rem_q, rem_d;
    logic [QUOTIENT_WIDTH-1:0] shift_q, shift_d;
    logic [CNT_WIDTH-1:0]      count_q, count_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic [QUOTIENT_WIDTH-1:0] quotient_q, quotient_d;

    logic [REM_WIDTH-1:0]      rem_shift;
    logic [REM_WIDTH-1:0]      rem_sub;
    logic                      q_bit;

    // Next-state and datapath; the shifted-in remainder bit is always 1 (numerator offset by -1)
    always_comb begin
        state_d    = state_q;
        cls_d      = cls_q;
        divisor_d  = divisor_q;
        rem_d      = rem_q;
        shift_d    = shift_q;
        count_d    = count_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        quotient_d = quotient_q;

        rem_shift = {rem_q[REM_WIDTH-2:0], 1'b1};
        rem_sub   = rem_shift - REM_WIDTH'(divisor_q);
        q_bit     = (rem_shift >= REM_WIDTH'(divisor_q));

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    divisor_d = divisor;
                    rem_d     = REM_WIDTH'(dividend) - REM_WIDTH'(1);
                    shift_d   = '0;
                    count_d   = '0;
                    busy_d    = 1'b1;
                    state_d   = S_RUN;
                    if (dividend == '0)
                        cls_d = C_ZERO;
                    else if ((divisor == '0) || (dividend >= divisor))
                        cls_d = C_SAT;
                    else
                        cls_d = C_NORM;
                end
            end
            S_RUN: begin
                // Special cases iterate too so that latency is constant
                rem_d   = q_bit ? rem_sub : rem_shift;
                shift_d = (shift_q << 1) | QUOTIENT_WIDTH'(q_bit);
                count_d = count_q + CNT_WIDTH'(1);
                if (count_q == CNT_WIDTH'(QUOTIENT_WIDTH - 1))
                    state_d = S_FINISH;
            end
            S_FINISH: begin
                case (cls_q)
                    C_ZERO:  quotient_d = '0;
                    C_SAT:   quotient_d = Q_FULL;
                    default: quotient_d = shift_q;
                endcase
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cls_q      <= C_NORM;
            divisor_q  <= '0;
            rem_q      <= '0;
            shift_q    <= '0;
            count_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            quotient_q <= '0;
        end else begin
            state_q    <= state_d;
            cls_q      <= cls_d;
            divisor_q  <= divisor_d;
            rem_q      <= rem_d;
            shift_q    <= shift_d;
            count_q    <= count_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            quotient_q <= quotient_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign quotient = quotient_q;

endmodule

// File: tb/tb_divide.sv
// Scoreboard bench for divide: stimulus pushes expected quotients, a negedge monitor
// pops and checks value and latency on every done pulse.
module tb_divide;

    localparam int unsigned DW = 16;
    localparam int unsigned QW = 8;
    localparam int unsigned LATENCY = 9;

    logic          clock;
    logic          reset;
    logic          start;
    logic [DW-1:0] dividend;
    logic [DW-1:0] divisor;
    logic          busy;
    logic          done;
    logic [QW-1:0] quotient;

    typedef struct {
        logic [QW-1:0] q;
        int unsigned   start_cyc;
    } exp_t;

    exp_t          exp_q[$];
    int unsigned   cyc = 0;
    logic          rst_edge = 1'b1;
    logic [QW-1:0] prev_quot = '0;
    int            checks = 0;
    int            failures = 0;

    divide #(.DIVIDEND_WIDTH(DW), .QUOTIENT_WIDTH(QW)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .dividend (dividend),
        .divisor  (divisor),
        .busy     (busy),
        .done     (done),
        .quotient (quotient)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        cyc++;
        rst_edge = reset;
    end

    // Reference: floor((a*2^QW - 1)/b) with saturation and zero handling
    function automatic logic [QW-1:0] ref_q(input int unsigned a, input int unsigned b);
        longint unsigned n;
        if (a == 0) return '0;
        if ((b == 0) || (a >= b)) return '1;
        n = (longint'(a) << QW) - 1;
        return QW'(n / longint'(b));
    endfunction

    // Monitor
    always @(negedge clock) begin
        exp_t e;
        if (done) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_done: got quotient=%0d at cycle %0d, required no done", quotient, cyc);
            end else begin
                e = exp_q.pop_front();
                checks++;
                if (quotient !== e.q) begin
                    failures++;
                    $display("FAIL quotient: got %0d required %0d (start cycle %0d)", quotient, e.q, e.start_cyc);
                end
                checks++;
                if (cyc - e.start_cyc != LATENCY) begin
                    failures++;
                    $display("FAIL latency: got %0d required %0d", cyc - e.start_cyc, LATENCY);
                end
            end
            checks++;
            if (busy !== 1'b0) begin
                failures++;
                $display("FAIL done_busy_overlap: got busy=%b required 0", busy);
            end
        end else if (!rst_edge && (quotient !== prev_quot)) begin
            checks++;
            failures++;
            $display("FAIL quotient_stable: got %0d required %0d (no done)", quotient, prev_quot);
        end
        prev_quot = quotient;
    end

    task automatic wait_done();
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clock);
            if (done) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL done_timeout: got no done within 20 cycles, required done");
        end
    endtask

    task automatic run_op(input int unsigned a, input int unsigned b, input logic [QW-1:0] e);
        exp_t item;
        @(negedge clock);
        dividend = DW'(a);
        divisor  = DW'(b);
        start    = 1'b1;
        item.q         = e;
        item.start_cyc = cyc + 1;
        exp_q.push_back(item);
        @(negedge clock);
        start    = 1'b0;
        dividend = DW'($urandom);
        divisor  = DW'($urandom);
        wait_done();
    endtask

    int unsigned vec_a[14] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 20, 0, 5, 65535};
    int unsigned vec_b[14] = '{10, 10, 10, 10, 10, 10, 10, 10, 10, 10, 10, 10, 0, 65535};
    int unsigned vec_e[14] = '{25, 51, 76, 102, 127, 153, 179, 204, 230, 255, 255, 0, 255, 255};
    int unsigned wide_a[3] = '{1, 32768, 300};
    int unsigned wide_b[3] = '{65535, 65535, 1000};
    int unsigned wide_e[3] = '{0, 128, 76};

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned a;
        int unsigned b;
        exp_t item;

        reset = 1'b1;
        start = 1'b0;
        dividend = '0;
        divisor = '0;
        repeat (3) @(negedge clock);
        checks += 3;
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b required 0", busy); end
        if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b required 0", done); end
        if (quotient !== '0) begin failures++; $display("FAIL reset_quotient: got %0d required 0", quotient); end
        reset = 1'b0;

        for (int i = 0; i < 14; i++) run_op(vec_a[i], vec_b[i], QW'(vec_e[i]));
        for (int i = 0; i < 3; i++) run_op(wide_a[i], wide_b[i], QW'(wide_e[i]));

        // Second start while busy must be ignored
        @(negedge clock);
        dividend = 16'd5;
        divisor  = 16'd10;
        start    = 1'b1;
        item.q = 8'd127;
        item.start_cyc = cyc + 1;
        exp_q.push_back(item);
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL hs_busy: got %b required 1", busy); end
        dividend = 16'd9;
        divisor  = 16'd10;
        start    = 1'b1;
        @(negedge clock);
        start = 1'b0;
        wait_done();
        repeat (12) @(negedge clock);

        // Reset during RUN aborts the operation
        @(negedge clock);
        dividend = 16'd3;
        divisor  = 16'd10;
        start    = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        checks += 3;
        if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy: got %b required 0", busy); end
        if (done !== 1'b0) begin failures++; $display("FAIL abort_done: got %b required 0", done); end
        if (quotient !== '0) begin failures++; $display("FAIL abort_quotient: got %0d required 0", quotient); end
        repeat (15) @(negedge clock);
        run_op(7, 10, 8'd179);

        // Random regression
        for (int i = 0; i < 1000; i++) begin
            b = $urandom_range(0, 65535);
            case ($urandom_range(0, 3))
                0:       a = $urandom_range(0, 65535);
                default: a = $urandom_range(0, b);
            endcase
            run_op(a, b, ref_q(a, b));
        end

        repeat (3) @(negedge clock);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/divide.md
Name: divide

Overview:
- Sequential fixed-point fraction divider. Computes dividend/divisor as an unsigned fraction scaled to a full-scale QUOTIENT_WIDTH-bit code (255 = ratio of 1.0).
- Sits in the pipeline, converting a measured period ratio (PERIOD_WIDTH operands) into a LONG_PERCENT_WIDTH percentage code.
- Iterative restoring division: one quotient bit per clock behind a start/done handshake.

Parameters:
- DIVIDEND_WIDTH, 16 (CONFIG::PERIOD_WIDTH), width of dividend and divisor.
- QUOTIENT_WIDTH, 8 (CONFIG::LONG_PERCENT_WIDTH), width of quotient; also the number of iteration cycles.

Ports:
- clock  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when busy=0.
- dividend  input  DIVIDEND_WIDTH  unsigned numerator; sampled at the accepted start edge.
- divisor  input  DIVIDEND_WIDTH  unsigned denominator; sampled at the accepted start edge.
- busy  output  1  high while an operation is in flight.
- done  output  1  one-cycle pulse when quotient is updated.
- quotient  output  QUOTIENT_WIDTH  result; holds its value until the next done.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset: busy=0, done=0, quotient=0, FSM to IDLE. Reset wins over start.
- Reset mid-operation aborts the operation. No done pulse is produced and quotient is 0.
- Result function, with Q = 2^QUOTIENT_WIDTH - 1:
  - dividend=0 -> 0.
  - divisor=0 with dividend>0 -> Q.
  - dividend>=divisor -> Q (saturate; dividend==divisor gives exactly Q).
  - otherwise quotient = floor((dividend*2^QUOTIENT_WIDTH - 1)/divisor), which equals ceil(dividend*2^QUOTIENT_WIDTH/divisor) - 1.
- Algorithm, for the normal case 0<dividend<divisor:
  - Numerator = (dividend-1)*2^QUOTIENT_WIDTH + (2^QUOTIENT_WIDTH - 1).
  - Initialise partial remainder R = dividend-1 (always < divisor).
  - Each iteration: R = (R<<1)|1, where the shifted-in bit is a 1 every iteration.
  - If R>=divisor: R -= divisor and the quotient bit is 1; else the bit is 0.
  - Bits are produced MSB first.
  - R needs DIVIDEND_WIDTH+1 bits. No wider multiply or divide operators are used.
- FSM: IDLE -> RUN -> FINISH -> IDLE.
  - IDLE: on an edge with start=1, latch operands, classify the special cases, clear the bit counter and go to RUN; busy=1 from the next cycle.
  - RUN: exactly QUOTIENT_WIDTH edges, one quotient bit per edge. Special cases also spend these cycles, so latency is constant.
  - FINISH edge: write quotient (the special-case value or the shift register), go to IDLE, drive done=1 for that following cycle, busy=0.
- Latency: done is high in the cycle after edge QUOTIENT_WIDTH+1, counting the start edge as edge 0. That is 9 cycles for the defaults.
- start while busy=1 is ignored. Input changes after the start edge do not affect the result.
- start held high in IDLE (including the done cycle) launches back-to-back operations.
- done never overlaps busy. quotient is stable except in the cycle done asserts.

Test Plan:
- Divisor=10, dividend 1..10 in turn. Required quotients: 25, 51, 76, 102, 127, 153, 179, 204, 230, 255, each arriving with done exactly 9 cycles after start.
- Saturation and zero cases:
  - dividend=20, divisor=10 -> 255.
  - dividend=0, divisor=10 -> 0.
  - dividend=5, divisor=0 -> 255.
  - dividend=65535, divisor=65535 -> 255.
- Wide operands:
  - dividend=1, divisor=65535 -> 0.
  - dividend=32768, divisor=65535 -> 128 (floor(8388607/65535)).
  - dividend=300, divisor=1000 -> 76.
- Handshake:
  - Pulse start, then change the inputs and assert start again while busy=1. The second request is ignored.
  - The result matches the first operands, with a single done pulse.
- Reset mid-operation: assert reset at cycle 4 of RUN. Next cycle busy=0, done=0, quotient=0, and no later done. A new start then completes normally.
- Random regression: 1000 random operand pairs checked against the reference formula and the 9-cycle latency.
